// File: rtl/i_ref_sweep_ctrl.sv
// Current-reference sweep controller: steps i_ref upward, strobes a sampler after settling,
// and backs off to the sampler's oldest history entry on synchronized instability.
module i_ref_sweep_ctrl #(
  parameter int BUS_WIDTH     = 10,
  parameter int I_START       = 0,
  parameter int STEP          = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int MIN_SAMPLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 unstable_in,
  input  logic [BUS_WIDTH-1:0] i_ref_max,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 ready,
  output logic                 went_unstable,
  output logic                 busy,
  output logic                 done,
  output logic                 saturated,
  output logic                 fault
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = $clog2(MIN_SAMPLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETTLE   = 3'd1;
  localparam logic [2:0] S_SAMPLE   = 3'd2;
  localparam logic [2:0] S_UNSTABLE = 3'd3;
  localparam logic [2:0] S_APPLY    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  localparam logic [BUS_WIDTH-1:0] I_START_W = BUS_WIDTH'(I_START);
  localparam logic [BUS_WIDTH:0]   STEP_W    = (BUS_WIDTH+1)'(STEP);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]        SAMP_MIN  = SW'(MIN_SAMPLES);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BUS_WIDTH-1:0] iref_q, iref_d;
  logic                 sat_q, sat_d;
  logic                 sync1_q, unst_s_q;
  logic                 ready_q, wu_q, busy_q, done_q, fault_q;
  logic [BUS_WIDTH:0]   sum;

  // Extra MSB catches a step past the top of the reference range.
  assign sum = {1'b0, iref_q} + STEP_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    iref_d  = iref_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        iref_d = I_START_W;
        sat_d  = 1'b0;
        if (enable) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          samp_d  = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!enable) begin
          state_d = S_IDLE;
          iref_d  = I_START_W;
        end else if (unst_s_q) begin
          if (samp_q >= SAMP_MIN) begin
            state_d = S_UNSTABLE;
          end else begin
            state_d = S_FAULT;
            iref_d  = I_START_W;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (samp_q < SAMP_MIN) samp_d = samp_q + 1'b1;
        if (!enable) begin
          state_d = S_IDLE;
          iref_d  = I_START_W;
        end else if (sum[BUS_WIDTH]) begin
          state_d = S_DONE;
          sat_d   = 1'b1;
        end else begin
          iref_d  = sum[BUS_WIDTH-1:0];
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_UNSTABLE: state_d = S_APPLY;
      S_APPLY: begin
        iref_d  = i_ref_max;
        state_d = S_DONE;
      end
      S_DONE, S_FAULT: begin
        if (!enable) begin
          state_d = S_IDLE;
          iref_d  = I_START_W;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        iref_d  = I_START_W;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      samp_q   <= '0;
      iref_q   <= I_START_W;
      sat_q    <= 1'b0;
      sync1_q  <= 1'b0;
      unst_s_q <= 1'b0;
      ready_q  <= 1'b0;
      wu_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      iref_q   <= iref_d;
      sat_q    <= sat_d;
      sync1_q  <= unstable_in;
      unst_s_q <= sync1_q;
      // Flags are decoded from the next state so they line up with the state register.
      ready_q  <= (state_d == S_SAMPLE);
      wu_q     <= (state_d == S_UNSTABLE);
      busy_q   <= (state_d == S_SETTLE) || (state_d == S_SAMPLE) ||
                  (state_d == S_UNSTABLE) || (state_d == S_APPLY);
      done_q   <= (state_d == S_DONE);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign i_ref         = iref_q;
  assign ready         = ready_q;
  assign went_unstable = wu_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign saturated     = sat_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_i_ref_sweep_ctrl.sv
// Bench for i_ref_sweep_ctrl with an attached 4-deep sample-history model.
module tb_i_ref_sweep_ctrl;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst, enable, unstable_in;
  logic [BW-1:0] i_ref_max, i_ref;
  logic          ready, went_unstable, busy, done, saturated, fault;
  logic [BW-1:0] hist [4];

  int n_chk = 0, n_fail = 0, cyc = 0, last_rdy = -1, wu_cnt = 0, wu_cyc = 0;
  int exp_q[$];

  typedef struct {
    int unst_at;
    int n_ready;
    int exp_done;
    int exp_sat;
    int exp_fault;
    int exp_iref;
    int exp_wu;
  } vec_t;
  vec_t vecs[5];

  i_ref_sweep_ctrl #(
    .BUS_WIDTH(BW), .I_START(0), .STEP(16), .SETTLE_CYCLES(8), .MIN_SAMPLES(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .unstable_in(unstable_in),
    .i_ref_max(i_ref_max), .i_ref(i_ref), .ready(ready),
    .went_unstable(went_unstable), .busy(busy), .done(done),
    .saturated(saturated), .fault(fault)
  );

  always #5 clk = ~clk;

  // Sampler: shifts i_ref in on ready, presents the oldest entry after went_unstable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      i_ref_max <= '0;
    end else begin
      if (ready) begin
        hist[0] <= i_ref;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      end
      if (went_unstable) i_ref_max <= hist[3];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ready) begin
      if (exp_q.size() == 0) chk("ready_unexpected", int'(i_ref), -1);
      else chk("ready_iref", int'(i_ref), exp_q.pop_front());
      if (last_rdy >= 0) chk("ready_gap", cyc - last_rdy, 9);
      last_rdy = cyc;
      chk("ready_with_wu", int'(went_unstable), 0);
    end
    if (went_unstable) begin
      wu_cnt++;
      wu_cyc = cyc;
    end
  endtask

  task automatic wait_iref(input int v, input int lim);
    int k;
    k = 0;
    while (int'(i_ref) != v && k < lim) begin
      step();
      k++;
    end
    chk("wait_iref", int'(i_ref), v);
  endtask

  task automatic push_ramp(input int n);
    for (int r = 0; r < n; r++) exp_q.push_back(r * 16);
  endtask

  task automatic cleanup();
    enable      = 1'b0;
    unstable_in = 1'b0;
    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    vecs[0] = '{96, 6, 1, 0, 0, 32, 1};    // normal back-off
    vecs[1] = '{32, 2, 0, 0, 1, 0, 0};     // early fault
    vecs[2] = '{-1, 64, 1, 1, 0, 1008, 0}; // saturation
    vecs[3] = '{64, 4, 1, 0, 0, 0, 1};     // exactly MIN_SAMPLES taken
    vecs[4] = '{48, 3, 0, 0, 1, 0, 0};     // one short of MIN_SAMPLES

    rst = 1'b1; enable = 1'b1; unstable_in = 1'b0;
    repeat (2) begin
      step();
      chk("reset_iref", int'(i_ref), 0);
      chk("reset_flags", int'({ready, went_unstable, busy, done, saturated, fault}), 0);
    end
    rst = 1'b0;
    step();
    chk("settle_after_reset", int'(busy), 1);
    cleanup();

    for (int v = 0; v < 5; v++) begin
      last_rdy = -1; wu_cnt = 0; wu_cyc = -100;
      push_ramp(vecs[v].n_ready);
      enable = 1'b1;
      k = 0;
      while (!(done || fault) && k < 1500) begin
        step();
        k++;
        if (vecs[v].unst_at >= 0 && busy && int'(i_ref) == vecs[v].unst_at) unstable_in = 1'b1;
      end
      chk("vec_done", int'(done), vecs[v].exp_done);
      chk("vec_saturated", int'(saturated), vecs[v].exp_sat);
      chk("vec_fault", int'(fault), vecs[v].exp_fault);
      chk("vec_iref", int'(i_ref), vecs[v].exp_iref);
      chk("vec_wu_count", wu_cnt, vecs[v].exp_wu);
      chk("vec_queue", exp_q.size(), 0);
      if (vecs[v].exp_wu == 1) chk("done_latency", cyc - wu_cyc, 2);
      enable = 1'b0;
      unstable_in = 1'b0;
      step();
      chk("idle_iref", int'(i_ref), 0);
      chk("idle_flags", int'({busy, done, saturated, fault}), 0);
      cleanup();
    end

    // Abort at cnt=3 of the i_ref=48 settle, then restart with a fresh sample count.
    last_rdy = -1; wu_cnt = 0;
    push_ramp(3);
    enable = 1'b1;
    wait_iref(48, 200);
    repeat (3) step();
    enable = 1'b0;
    step();
    chk("abort_iref", int'(i_ref), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_queue", exp_q.size(), 0);
    last_rdy = -1;
    push_ramp(2);
    enable = 1'b1;
    wait_iref(32, 200);
    unstable_in = 1'b1;
    k = 0;
    while (!fault && k < 50) begin step(); k++; end
    chk("abort_refault", int'(fault), 1);
    chk("abort_refault_iref", int'(i_ref), 0);
    chk("abort_refault_wu", wu_cnt, 0);
    cleanup();

    // 3-cycle instability pulse from cnt=2: decision lands at the end of cnt=4.
    last_rdy = -1; wu_cnt = 0;
    push_ramp(2);
    enable = 1'b1;
    wait_iref(32, 200);
    repeat (2) step();
    unstable_in = 1'b1;
    step();
    chk("sync_cnt3_fault", int'(fault), 0);
    step();
    chk("sync_cnt4_fault", int'(fault), 0);
    chk("sync_cnt4_busy", int'(busy), 1);
    step();
    chk("sync_fault", int'(fault), 1);
    unstable_in = 1'b0;
    cleanup();

    // enable dropped during UNSTABLE: back-off still completes, then IDLE.
    last_rdy = -1; wu_cnt = 0;
    push_ramp(6);
    enable = 1'b1;
    wait_iref(96, 200);
    unstable_in = 1'b1;
    k = 0;
    while (!went_unstable && k < 50) begin step(); k++; end
    chk("late_wu", int'(went_unstable), 1);
    enable = 1'b0;
    step();
    chk("late_apply_busy", int'(busy), 1);
    step();
    chk("late_done", int'(done), 1);
    chk("late_iref", int'(i_ref), 32);
    step();
    chk("late_idle_done", int'(done), 0);
    chk("late_idle_iref", int'(i_ref), 0);
    cleanup();

    // Reset mid-sweep with enable still high restarts from I_START.
    last_rdy = -1;
    push_ramp(3);
    enable = 1'b1;
    wait_iref(48, 200);
    rst = 1'b1;
    step();
    chk("midrst_iref", int'(i_ref), 0);
    chk("midrst_flags", int'({ready, busy}), 0);
    rst = 1'b0;
    last_rdy = -1;
    exp_q.push_back(0);
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin step(); k++; end
    chk("midrst_restart", exp_q.size(), 0);
    cleanup();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
